// File: rtl/button_pkg.sv
// Shared types and defaults for the pushbutton conditioner.
// Optional feature macro: BUTTON_CONDITIONER_AUTOREPEAT_EN.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 25000;

endpackage

// File: rtl/button_debounce_ch.sv
// Single pushbutton channel: 2-flop synchroniser, debounce FSM, registered
// level/press/release outputs. Auto-repeat on held buttons is built only when
// BUTTON_CONDITIONER_AUTOREPEAT_EN is defined.
module button_debounce_ch
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 2500000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  btn_state_t    state;

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = (RMAX > 2) ? $clog2(RMAX) : 1;

  logic [RW-1:0] rpt_cnt;
  logic          rpt_first;
  logic [RW-1:0] rpt_last;

  // First repeat waits the long delay, later ones the shorter period.
  assign rpt_last = rpt_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
`else
  // Repeat timing has no consumer in this build.
  if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_repeat_unused
  end
`endif

  // Two-flop synchroniser for the asynchronous button level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Debounce FSM with registered level and single-cycle strobes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
      rpt_cnt     <= '0;
      rpt_first   <= 1'b1;
`endif
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      case (state)
        IDLE: begin
          if (sync2) begin
            state <= PRESS_WAIT;
            cnt   <= CW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!sync2) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state     <= HELD;
            btn_level <= 1'b1;
            btn_press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!sync2) begin
            state <= RELEASE_WAIT;
            cnt   <= CW'(1);
          end
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
          else if (rpt_cnt == rpt_last) begin
            btn_press <= 1'b1;
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
`endif
        end
        RELEASE_WAIT: begin
          if (sync2) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state       <= IDLE;
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
            rpt_cnt     <= '0;
            rpt_first   <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Pushbutton front end: N_BTN independent debounced channels feeding the
// seven-segment digit loaders. Optional auto-repeat via
// BUTTON_CONDITIONER_AUTOREPEAT_EN.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 2500000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  // One conditioner per button; outputs are bit-concatenated.
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clock      (clock),
      .reset_n    (reset_n),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i])
    );
  end

endmodule
